// File: rtl/turtle_cpu_pkg.sv
// Shared definitions for the turtle CPU: program-loader sync byte and FSM states.
package turtle_cpu_pkg;

    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/loader_watchdog.sv
// Inter-byte idle watchdog for the program loader. Counts enabled cycles
// since the last clear; o_expired flags the TIMEOUT_CYCLES-th idle cycle.
// TIMEOUT_CYCLES = 0 disables the watchdog.
module loader_watchdog #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_active;

    assign w_active  = (TIMEOUT_CYCLES != 0);
    assign o_expired = w_active && i_enable && !i_clear && (r_count == LAST);

    // Idle-cycle counter: cleared by activity, saturates at the final count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Program loader: parses SYNC/LEN/payload/CHK frames from the UART byte
// stream, writes assembled words to instruction memory from address 0, and
// holds the CPU in reset until a checksum-verified load completes.
//
// Byte handshake: rx_valid is a one-cycle strobe; a byte is consumed on every
// clock edge where rx_valid=1. There is no back-pressure, so the loader
// accepts a byte every cycle and a memory write overlaps the next byte.
module imem_uart_loader
    import turtle_cpu_pkg::*;
#(
    parameter int INSTR_W        = 16,
    parameter int IMEM_DEPTH     = 256,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int HOLD_AT_RESET  = 1,
    localparam int ADDR_W        = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [INSTR_W-1:0]  imem_wdata,
    output logic                cpu_hold_n,
    output logic                load_done,
    output logic                load_error,
    output logic [15:0]         words_loaded,
    output loader_state_t       dbg_state
);

    localparam int BPW = INSTR_W / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

    loader_state_t       r_state;
    logic [15:0]         r_len;
    logic [BCW-1:0]      r_byte_cnt;
    logic [INSTR_W-1:0]  r_word;
    logic [7:0]          r_xor;
    logic                r_imem_we;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [INSTR_W-1:0]  r_imem_wdata;
    logic [15:0]         r_words_loaded;
    logic                r_load_done;
    logic                r_load_error;
    logic                r_cpu_hold_n;

    logic                w_in_frame;
    logic                w_wd_expired;
    logic [15:0]         w_len;
    logic                w_len_bad;
    logic [INSTR_W-1:0]  w_next_word;

    assign w_in_frame  = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                         (r_state == ST_DATA)   || (r_state == ST_CHECK);
    assign w_len       = {r_len[15:8], rx_data};
    assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > 17'(IMEM_DEPTH));
    assign w_next_word = (r_word << 8) | INSTR_W'(rx_data);

    loader_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (rx_valid || !w_in_frame),
        .i_enable  (w_in_frame),
        .o_expired (w_wd_expired)
    );

    // Frame FSM with word assembly, checksum, address counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_len          <= '0;
            r_byte_cnt     <= '0;
            r_word         <= '0;
            r_xor          <= '0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
            r_words_loaded <= '0;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
            r_cpu_hold_n   <= (HOLD_AT_RESET != 0) ? 1'b0 : 1'b1;
        end else begin
            r_imem_we <= 1'b0;
            if (w_wd_expired) begin
                r_state      <= ST_ERROR;
                r_load_error <= 1'b1;
            end else if (rx_valid) begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (rx_data == LOADER_SYNC_BYTE) begin
                            r_state        <= ST_LEN_HI;
                            r_words_loaded <= '0;
                            r_xor          <= '0;
                            r_byte_cnt     <= '0;
                            r_load_done    <= 1'b0;
                            r_load_error   <= 1'b0;
                            r_cpu_hold_n   <= 1'b0;
                        end
                    end
                    ST_LEN_HI: begin
                        r_len[15:8] <= rx_data;
                        r_state     <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        r_len <= w_len;
                        if (w_len_bad) begin
                            r_state      <= ST_ERROR;
                            r_load_error <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_xor  <= r_xor ^ rx_data;
                        r_word <= w_next_word;
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_byte_cnt     <= '0;
                            r_imem_we      <= 1'b1;
                            r_imem_wdata   <= w_next_word;
                            r_imem_addr    <= r_words_loaded[ADDR_W-1:0];
                            r_words_loaded <= r_words_loaded + 16'd1;
                            if ((r_words_loaded + 16'd1) == r_len) begin
                                r_state <= ST_CHECK;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BCW'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (rx_data == r_xor) begin
                            r_state      <= ST_DONE;
                            r_load_done  <= 1'b1;
                            r_cpu_hold_n <= 1'b1;
                        end else begin
                            r_state      <= ST_ERROR;
                            r_load_error <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign cpu_hold_n   = r_cpu_hold_n;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;
    assign words_loaded = r_words_loaded;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: a frame-level model predicts the
// memory writes and final status of each frame; a per-cycle process checks
// every write pulse against the expected queue.
module tb_imem_uart_loader;
    import turtle_cpu_pkg::*;

    localparam int INSTR_W = 16;
    localparam int DEPTH   = 256;
    localparam int TMO     = 20;
    localparam int ADDR_W  = 8;

    logic                clk;
    logic                reset_n;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                imem_we;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_wdata;
    logic                cpu_hold_n;
    logic                load_done;
    logic                load_error;
    logic [15:0]         words_loaded;
    loader_state_t       dbg_state;

    imem_uart_loader #(
        .INSTR_W        (INSTR_W),
        .IMEM_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .HOLD_AT_RESET  (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold_n   (cpu_hold_n),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+INSTR_W-1:0] exp_q[$];
    logic [7:0]                frame_q[$];
    logic [INSTR_W-1:0]        obs_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every write pulse must match the next expected write
    always @(negedge clk) begin
        if (reset_n && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0h data=%0h required=no_write", imem_addr, imem_wdata);
            end else begin
                logic [ADDR_W+INSTR_W-1:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e[ADDR_W+INSTR_W-1:INSTR_W]));
                check("write_data", 32'(imem_wdata), 32'(e[INSTR_W-1:0]));
                check("words_at_write", 32'(words_loaded), 32'(e[ADDR_W+INSTR_W-1:INSTR_W]) + 1);
            end
            obs_mem[imem_addr] = imem_wdata;
        end
    end

    // driver tasks
    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic load_bytes(input logic [255:0] v, input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(v[(n-1-i)*8 +: 8]);
    endtask

    // drive frame_q from index 'start'; an idle gap of gap_len before byte gap_at
    task automatic send_frame(input int start, input int gap_at, input int gap_len);
        for (int i = start; i < frame_q.size(); i++) begin
            if (i == gap_at) drive_idle(gap_len);
            drive_byte(frame_q[i]);
        end
        drive_idle(1);
    endtask

    // frame-level model: res 0=incomplete, 1=verified, 2=rejected
    task automatic model_frame(output int res, output int nw);
        int len;
        int avail;
        logic [7:0]  x;
        logic [15:0] w;
        res = 0;
        nw  = 0;
        if (frame_q.size() < 3) return;
        len = {16'd0, frame_q[1], frame_q[2]};
        if (len == 0 || len > DEPTH) begin
            res = 2;
            return;
        end
        avail = (frame_q.size() - 3) / 2;
        if (avail > len) avail = len;
        x = 8'h00;
        for (int i = 0; i < avail; i++) begin
            w = {frame_q[3+2*i], frame_q[4+2*i]};
            x = x ^ frame_q[3+2*i] ^ frame_q[4+2*i];
            exp_q.push_back({8'(i), w});
        end
        nw = avail;
        if (frame_q.size() > 3 + 2*len) res = (frame_q[3+2*len] == x) ? 1 : 2;
    endtask

    task automatic check_status(input string tag, input logic done, input logic err, input int nw);
        drive_idle(4);
        @(negedge clk);
        check({tag, "_done"},  32'(load_done),  32'(done));
        check({tag, "_error"}, 32'(load_error), 32'(err));
        check({tag, "_hold_n"}, 32'(cpu_hold_n), 32'(done));
        check({tag, "_words"}, 32'(words_loaded), 32'(nw));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int gap_at, input int gap_len);
        int res;
        int nw;
        model_frame(res, nw);
        send_frame(0, gap_at, gap_len);
        check_status(tag, res == 1, res == 2, nw);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int res;
        int nw;
        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        drive_idle(3);
        @(negedge clk);
        check("reset_we", 32'(imem_we), 32'd0);
        check("reset_addr", 32'(imem_addr), 32'd0);
        check("reset_wdata", 32'(imem_wdata), 32'd0);
        check("reset_hold_n", 32'(cpu_hold_n), 32'd0);
        check("reset_done", 32'(load_done), 32'd0);
        check("reset_error", 32'(load_error), 32'd0);
        check("reset_words", 32'(words_loaded), 32'd0);
        reset_n = 1'b1;
        drive_idle(2);

        // 1: basic frame, noise before SYNC, idle gap mid-frame
        drive_byte(8'h3C);
        drive_byte(8'h00);
        drive_idle(2);
        load_bytes(256'hA5_0002_1234_ABCD_40, 8);
        run_frame("t1", 4, 3);
        check("t1_mem0", 32'(obs_mem[0]), 32'h1234);
        check("t1_mem1", 32'(obs_mem[1]), 32'hABCD);
        check("t1_words_lit", 32'(words_loaded), 32'd2);
        check("t1_hold_lit", 32'(cpu_hold_n), 32'd1);

        // 2: bad checksum; words still written
        load_bytes(256'hA5_0002_1234_ABCD_41, 8);
        run_frame("t2", -1, 0);
        check("t2_error_lit", 32'(load_error), 32'd1);
        check("t2_hold_lit", 32'(cpu_hold_n), 32'd0);

        // 3: LEN = 0 and LEN = DEPTH+1 rejected, trailing bytes ignored
        load_bytes(256'hA5_0000_1122, 5);
        run_frame("t3a", -1, 0);
        load_bytes(256'hA5_0101_1122_3344, 7);
        run_frame("t3b", -1, 0);

        // 4: back-to-back 4-word frame, 0xA5 inside payload and as CHK
        load_bytes(256'hA5_0004_A501_0203_0405_0607_A5, 12);
        run_frame("t4", -1, 0);
        check("t4_mem0", 32'(obs_mem[0]), 32'hA501);
        check("t4_mem3", 32'(obs_mem[3]), 32'h0607);

        // 5a: stall TMO cycles mid-DATA -> error, one word written
        load_bytes(256'hA5_0002_1234_AB, 6);
        model_frame(res, nw);
        send_frame(0, -1, 0);
        drive_idle(TMO - 1);
        check_status("t5a", 1'b0, 1'b1, nw);
        // 5b: stall TMO-1 cycles mid-DATA -> completes
        load_bytes(256'hA5_0002_1122_3344_44, 8);
        model_frame(res, nw);
        send_frame(0, 5, TMO - 1);
        check_status("t5b", 1'b1, 1'b0, nw);

        // 6: reset mid-frame, then a clean load from address 0
        load_bytes(256'hA5_0002_1234_AB, 6);
        model_frame(res, nw);
        send_frame(0, -1, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_rst_we", 32'(imem_we), 32'd0);
        check("t6_rst_addr", 32'(imem_addr), 32'd0);
        check("t6_rst_words", 32'(words_loaded), 32'd0);
        check("t6_rst_hold_n", 32'(cpu_hold_n), 32'd0);
        check("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t6_rst_pending", 32'(exp_q.size()), 32'd0);
        drive_idle(2);
        reset_n = 1'b1;
        load_bytes(256'hA5_0002_1234_ABCD_40, 8);
        run_frame("t6", -1, 0);
        // next SYNC after DONE: hold drops one cycle after acceptance
        load_bytes(256'hA5_0001_BEEF_51, 6);
        model_frame(res, nw);
        drive_byte(8'hA5);
        @(negedge clk);
        check("t6_hold_before", 32'(cpu_hold_n), 32'd1);
        drive_idle(1);
        @(negedge clk);
        check("t6_hold_after", 32'(cpu_hold_n), 32'd0);
        check("t6_done_clr", 32'(load_done), 32'd0);
        send_frame(1, -1, 0);
        check_status("t6b", res == 1, res == 2, nw);
        check("t6b_mem0", 32'(obs_mem[0]), 32'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
